// File: rtl/nco_pkg.sv
// ============================================================================
// Module : nco_pkg
// Brief  : Shared constants, correction-word type and chip-counter step
//          function for the tracking-channel NCO.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package nco_pkg;

    localparam int          c_acc_w      = 32;
    localparam int          c_out_w      = 3;
    localparam int          c_code_len   = 1023;
    localparam int          c_cnt_w      = 10;
    localparam logic [15:0] c_lfsr_seed  = 16'hACE1;
    // Feedback taps for x^16+x^14+x^13+x^11+1 (bits 15,13,12,10)
    localparam logic [15:0] c_lfsr_taps  = 16'hB400;

    typedef logic signed [c_acc_w-1:0] corr_word_t;

    // Next chip index after a forward or backward accumulator wrap.
    function automatic int unsigned chip_next(
        input int unsigned cnt,
        input logic        fwd,
        input logic        bwd,
        input int unsigned len
    );
        int unsigned nxt;
        nxt = cnt;
        if (fwd) begin
            nxt = (cnt == len - 1) ? 0 : cnt + 1;
        end else if (bwd) begin
            nxt = (cnt == 0) ? len - 1 : cnt - 1;
        end
        return nxt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/nco_dither_lfsr.sv
// ============================================================================
// Module : nco_dither_lfsr
// Brief  : 16-bit maximal-length Fibonacci LFSR used to dither the carrier
//          LUT index. Present only when NCO_DITHER_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

`ifdef NCO_DITHER_EN
module nco_dither_lfsr
    import nco_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        adv_i,
    output logic [15:0] lfsr_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[14:0], ^(lfsr_q & c_lfsr_taps)};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= c_lfsr_seed;
        end else if (adv_i) begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule
`endif

`default_nettype wire

// File: rtl/nco_chan.sv
// ============================================================================
// Module : nco_chan
// Brief  : Tracking-channel NCO: phase accumulator with signed correction,
//          wrap detection and modulo-CODE_LEN chip counter with epoch strobe.
//          Define NCO_DITHER_EN to dither the phase_msb LUT index.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module nco_chan
    import nco_pkg::*;
#(
    parameter int ACC_W    = c_acc_w,
    parameter int OUT_W    = c_out_w,
    parameter int CODE_LEN = c_code_len,
    parameter int CNT_W    = c_cnt_w
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             fcw_load,
    input  logic [ACC_W-1:0] fcw,
    input  logic             corr_valid,
    input  logic [ACC_W-1:0] correction,
    output logic             corr_ack,
    input  logic             sync_req,
    output logic [ACC_W-1:0] phase,
    output logic [OUT_W-1:0] phase_msb,
    output logic             wrap_fwd,
    output logic             wrap_bwd,
    output logic [CNT_W-1:0] chip_cnt,
    output logic             epoch
);

    logic [ACC_W-1:0] fcw_q;
    logic [ACC_W-1:0] corr_q;
    logic [ACC_W-1:0] phase_q;
    logic [ACC_W-1:0] phase_d;
    logic [CNT_W-1:0] chip_q;
    logic [CNT_W-1:0] chip_d;
    logic             corr_ack_q;
    logic             wrap_fwd_q;
    logic             wrap_bwd_q;
    logic             epoch_q;
    logic             epoch_d;

    logic [ACC_W:0]   w_step;
    logic [ACC_W:0]   w_sum;
    logic             w_step_neg;
    logic             w_step_zero;
    logic             w_fwd;
    logic             w_bwd;

    // Step is signed ACC_W+1: fcw zero-extended, correction sign-extended.
    always_comb begin
        w_step      = {1'b0, fcw_q} + {corr_q[ACC_W-1], corr_q};
        w_sum       = {1'b0, phase_q} + {1'b0, w_step[ACC_W-1:0]};
        w_step_neg  = w_step[ACC_W];
        w_step_zero = (w_step == '0);
        w_fwd       = en & ~sync_req & ~w_step_neg & ~w_step_zero & w_sum[ACC_W];
        w_bwd       = en & ~sync_req & w_step_neg & ~w_sum[ACC_W];

        phase_d = phase_q;
        chip_d  = chip_q;
        epoch_d = 1'b0;
        if (en) begin
            if (sync_req) begin
                phase_d = '0;
                chip_d  = '0;
            end else begin
                phase_d = w_sum[ACC_W-1:0];
                chip_d  = CNT_W'(chip_next(32'(chip_q), w_fwd, w_bwd,
                                           int'(CODE_LEN)));
                epoch_d = w_fwd && (chip_q == CNT_W'(CODE_LEN - 1));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fcw_q      <= '0;
            corr_q     <= '0;
            phase_q    <= '0;
            chip_q     <= '0;
            corr_ack_q <= 1'b0;
            wrap_fwd_q <= 1'b0;
            wrap_bwd_q <= 1'b0;
            epoch_q    <= 1'b0;
        end else begin
            if (fcw_load) begin
                fcw_q <= fcw;
            end
            if (corr_valid) begin
                corr_q <= correction;
            end
            corr_ack_q <= corr_valid;
            phase_q    <= phase_d;
            chip_q     <= chip_d;
            wrap_fwd_q <= w_fwd;
            wrap_bwd_q <= w_bwd;
            epoch_q    <= epoch_d;
        end
    end

`ifdef NCO_DITHER_EN
    localparam int c_dith_raw = ACC_W - OUT_W - 4;
    localparam int c_dith_w   = (c_dith_raw > 16) ? 16 :
                                ((c_dith_raw < 1) ? 1 : c_dith_raw);

    logic [15:0]      w_lfsr;
    logic [ACC_W-1:0] w_dith_phase;
    logic [OUT_W-1:0] msb_q;

    nco_dither_lfsr u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .adv_i  (en),
        .lfsr_o (w_lfsr)
    );

    // Dither only perturbs the LUT index; the true phase is never touched.
    assign w_dith_phase = phase_d + ACC_W'(w_lfsr[c_dith_w-1:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msb_q <= '0;
        end else if (en) begin
            msb_q <= w_dith_phase[ACC_W-1 -: OUT_W];
        end
    end

    assign phase_msb = msb_q;
`else
    assign phase_msb = phase_q[ACC_W-1 -: OUT_W];
`endif

    assign phase    = phase_q;
    assign chip_cnt = chip_q;
    assign corr_ack = corr_ack_q;
    assign wrap_fwd = wrap_fwd_q;
    assign wrap_bwd = wrap_bwd_q;
    assign epoch    = epoch_q;

endmodule

`default_nettype wire

// File: doc/nco_chan.md
Name: nco_chan

Overview:
- Parametrised next-generation numerically controlled oscillator for the GPS tracking channel.
- Phase accumulator stepped by a programmable base frequency word plus a signed loop-filter correction.
- Detects forward and backward wrap-around; keeps a modulo-CODE_LEN chip counter with an epoch strobe.
- Drives code generators and carrier mixers directly from registered outputs.

Parameters:
- ACC_W, 32, accumulator and frequency-word width in bits.
- OUT_W, 3, number of phase MSBs presented on phase_msb (carrier LUT index).
- CODE_LEN, 1023, chip-counter modulus (chips per code epoch).
- CNT_W, 10, chip-counter width; must satisfy 2^CNT_W >= CODE_LEN.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- en  in  1  accumulate enable; when low, all state holds.
- fcw_load  in  1  load base frequency word this cycle.
- fcw  in  ACC_W  unsigned base frequency word.
- corr_valid  in  1  correction word offered.
- correction  in  ACC_W  signed correction from the loop filter.
- corr_ack  out  1  one-cycle pulse acknowledging the accepted correction.
- sync_req  in  1  realign request: zero phase and chip count.
- phase  out  ACC_W  full accumulator value.
- phase_msb  out  OUT_W  phase[ACC_W-1 -: OUT_W].
- wrap_fwd  out  1  pulse on forward accumulator wrap.
- wrap_bwd  out  1  pulse on backward accumulator wrap.
- chip_cnt  out  CNT_W  current chip index, 0..CODE_LEN-1.
- epoch  out  1  pulse when chip_cnt rolls from CODE_LEN-1 to 0.

Behaviour:
- Reset (async, rst=1):
  - fcw_r, corr_r, phase, chip_cnt = 0.
  - corr_ack, wrap_fwd, wrap_bwd, epoch = 0.
  - Reset mid-operation discards all state immediately; no pending correction survives.
- Register loads:
  - fcw_load=1 → fcw_r <= fcw on that edge.
  - corr_valid=1 → corr_r <= correction on that edge; corr_ack=1 on the following cycle.
  - Loads are independent of en.
  - Back-to-back corr_valid: each is accepted, and corr_ack stays high for consecutive cycles.
- Step computation:
  - step = fcw_r + corr_r, computed in ACC_W+1 bits (fcw_r zero-extended, corr_r sign-extended).
  - Result is interpreted as signed ACC_W+1; phase update uses its low ACC_W bits (modulo 2^ACC_W).
  - A newly loaded fcw or correction affects the step from the cycle after the load edge. Simultaneous fcw_load and corr_valid both take effect together.
- Accumulate (en=1, sync_req=0):
  - phase <= phase + step[ACC_W-1:0].
  - wrap_fwd=1 when step > 0 and the unsigned sum carries out of ACC_W bits.
  - wrap_bwd=1 when step < 0 and no carry out occurs (borrow).
  - step = 0 → no wrap, phase holds.
  - wrap_fwd and wrap_bwd are never high together.
- Chip counter, registered on the same edge as the wrap:
  - Forward wrap → chip_cnt + 1; CODE_LEN-1 → 0 with epoch=1.
  - Backward wrap → chip_cnt - 1; 0 → CODE_LEN-1, with no epoch.
- Sync (sync_req=1, en=1):
  - phase <= 0, chip_cnt <= 0; no wrap or epoch pulse that cycle.
  - fcw_r and corr_r are kept.
  - sync_req has priority over accumulation.
- Hold (en=0):
  - phase and chip_cnt hold; all pulses are 0.
  - sync_req is ignored.
- Latency and outputs:
  - All outputs are registered.
  - Pulses last exactly one cycle, aligned with the updated phase and chip_cnt.

Optional Feature:
- Macro: NCO_DITHER_EN.
- Defined:
  - A 16-bit maximal LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset) advances every en cycle.
  - Its low (ACC_W-OUT_W-4) bits, clipped to a maximum of 16, are added to the phase used to form phase_msb only. This reduces spurs.
  - phase, the wrap outputs and chip_cnt are unaffected.
- Undefined:
  - phase_msb is the plain accumulator MSBs; no LFSR logic is present.

Decomposition:
- Package nco_pkg:
  - Default ACC_W, CODE_LEN, LFSR seed and taps constants.
  - typedef for the signed correction word.
  - function computing the chip-counter next value.
- Sub-module nco_dither_lfsr: the LFSR, instantiated only under NCO_DITHER_EN.

Test Plan:
- Reset/hold: rst pulse mid-run, then en=0 for 10 cycles → all outputs 0 and stable.
- Forward wrap: ACC_W=32, fcw=0x4000_0000, correction=0, en=1 → phase 0x4000_0000, 0x8000_0000, 0xC000_0000, 0; wrap_fwd on the 4th update only; chip_cnt=1.
- Epoch: CODE_LEN=4, fcw=0x8000_0000 → wrap_fwd every 2nd cycle; chip_cnt 1,2,3,0; epoch with the 0.
- Negative step: fcw=0x1000_0000, correction=-0x2000_0000 → step -0x1000_0000; first update phase=0xF000_0000, wrap_bwd=1, chip_cnt=CODE_LEN-1, no epoch.
- Correction timing: corr_valid one cycle with correction=5, fcw=10 → corr_ack next cycle; step=15 from the cycle after the load.
- Sync priority: sync_req with en=1 and a wrap pending → phase=0, chip_cnt=0, no pulses; fcw unchanged.
